// File: rtl/rr_grant_mux.sv
// rtl/rr_grant_mux.sv - burst forwarder that locks onto a one-hot arbiter grant
// Optional idle timeout in XFER: define RRM_IDLE_TIMEOUT_EN.
module rr_grant_mux #(
    parameter int DATA_W    = 8,
    parameter int BURST_LEN = 4,
    parameter int TIMEOUT   = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [3:0]            gnt,
    input  logic [4*DATA_W-1:0]   req_data,
    input  logic [3:0]            req_valid,
    output logic [3:0]            req_ready,
    output logic [DATA_W-1:0]     out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [1:0]            out_src,
    output logic                  busy,
    output logic                  burst_done,
    output logic                  gnt_err
);

    localparam int CNT_W = $clog2(BURST_LEN + 1);
    localparam logic [CNT_W-1:0] BURST_CNT = CNT_W'(BURST_LEN);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

    typedef enum logic [1:0] {IDLE, XFER, DRAIN} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [1:0]       owner;
    logic [1:0]       gnt_idx;
    logic [CNT_W-1:0] beat_cnt;
    logic             gnt_onehot;
    logic             gnt_multi;
    logic             room;
    logic             accept;
    logic             last_accept;
    logic             drain_exit;
    logic             force_drain;

    always_comb begin
        gnt_idx = 2'd0;
        if (gnt[3])      gnt_idx = 2'd3;
        else if (gnt[2]) gnt_idx = 2'd2;
        else if (gnt[1]) gnt_idx = 2'd1;
    end

    assign gnt_onehot  = (gnt != 4'd0) && ((gnt & (gnt - 4'd1)) == 4'd0);
    assign gnt_multi   = (gnt != 4'd0) && !gnt_onehot;
    assign room        = !out_valid || out_ready;
    assign accept      = |(req_ready & req_valid);
    assign last_accept = accept && (beat_cnt == LAST_BEAT);
    assign drain_exit  = !out_valid || out_ready;

`ifdef RRM_IDLE_TIMEOUT_EN
    localparam int IDLE_W = $clog2(TIMEOUT + 1);
    logic [IDLE_W-1:0] idle_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            idle_cnt <= '0;
        else if (state == XFER && !accept)
            idle_cnt <= idle_cnt + 1'b1;
        else
            idle_cnt <= '0;
    end

    assign force_drain = (state == XFER) && !accept && (idle_cnt == IDLE_W'(TIMEOUT - 1));
`else
    // No idle limit: a silent owner parks the block in XFER.
    assign force_drain = (TIMEOUT < 0);
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (gnt_onehot) state_nxt = XFER;
            XFER:    if (last_accept || force_drain) state_nxt = DRAIN;
            DRAIN:   if (drain_exit) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // req_ready deliberately has no path from req_valid.
    always_comb begin
        req_ready = 4'd0;
        if (state == XFER && room && beat_cnt < BURST_CNT)
            req_ready[owner] = 1'b1;
        busy = (state != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner      <= 2'd0;
            beat_cnt   <= '0;
            out_data   <= '0;
            out_valid  <= 1'b0;
            out_src    <= 2'd0;
            burst_done <= 1'b0;
            gnt_err    <= 1'b0;
        end else begin
            burst_done <= (state == DRAIN) && drain_exit;
            gnt_err    <= (state == IDLE) && gnt_multi;
            if (state == IDLE && gnt_onehot) begin
                owner    <= gnt_idx;
                beat_cnt <= '0;
            end
            if (accept) begin
                out_data  <= req_data[owner*DATA_W +: DATA_W];
                out_valid <= 1'b1;
                out_src   <= owner;
                beat_cnt  <= beat_cnt + 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/rr_grant_mux.md
# rr_grant_mux

Downstream consumer of the 4-way round-robin arbiter's one-hot grant. On a valid grant it locks onto the granted requester, forwards a fixed-length burst of that requester's data beats through one registered valid/ready output stage, then releases and waits for the next grant. It sits between the arbiter and the shared resource, so payload never switches sources mid-burst even if the arbiter's grant moves.

## Interface
- DATA_W, 8, width of one data beat.
- BURST_LEN, 4, beats per burst (1..15).
- TIMEOUT, 8, idle-cycle limit; used only with RRM_IDLE_TIMEOUT_EN.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-high; all state cleared while high.
- gnt  input  4  one-hot grant from arbiter; 0 = none.
- req_data  input  4*DATA_W  requester payloads; requester i at [i*DATA_W +: DATA_W].
- req_valid  input  4  per-requester beat valid.
- req_ready  output  4  per-requester beat accept; at most one bit high.
- out_data  output  DATA_W  registered forwarded beat.
- out_valid  output  1  out_data valid.
- out_ready  input  1  downstream accept.
- out_src  output  2  index of the owner that produced out_data.
- busy  output  1  high in XFER and DRAIN.
- burst_done  output  1  one-cycle pulse at burst end.
- gnt_err  output  1  one-cycle pulse when gnt is sampled multi-hot in IDLE.

## Operation
- States: IDLE, XFER, DRAIN.
- IDLE: gnt one-hot -> latch owner = index, clear beat_cnt, go XFER. gnt == 0 -> stay. gnt multi-hot -> pulse gnt_err, stay IDLE, latch nothing.
- XFER: req_ready[owner] = (!out_valid || out_ready) && beat_cnt < BURST_LEN; other req_ready bits 0. A beat is accepted when req_valid[owner] && req_ready[owner]. An accepted beat loads out_data, sets out_valid, sets out_src = owner and increments beat_cnt.
- XFER -> DRAIN on the edge that accepts beat BURST_LEN.
- Output register: out_valid clears on out_ready when no new beat loads. Load and drain in the same cycle give back-to-back throughput of 1 beat/cycle.
- DRAIN: req_ready = 0. Exit when out_valid == 0, or when out_valid && out_ready. Then go IDLE and assert burst_done for the next cycle.
- gnt is ignored outside IDLE; arbiter grant changes mid-burst have no effect.
- beat_cnt width is $clog2(BURST_LEN+1); it never wraps.
- The owner's req_valid dropping mid-burst only stalls the burst; it does not end it (see Configuration).

## Timing
- Reset values: out_data 0, out_valid 0, out_src 0, req_ready 0, busy 0, burst_done 0, gnt_err 0, state IDLE, beat_cnt 0.
- Reset asserted mid-burst aborts immediately. The in-flight out_valid beat is discarded and no burst_done is produced.
- Grant sampled at edge N -> XFER, busy and first possible req_ready from cycle N+1.
- Beat accepted at edge M -> out_valid/out_data visible from M+1.
- Minimum burst, always-ready sink, gnt at edge 0: beats accepted at edges 1..BURST_LEN. DRAIN from BURST_LEN+1; out_ready high -> IDLE at BURST_LEN+2, burst_done high that cycle.
- The earliest new grant is sampled at the edge following burst_done's assertion cycle (IDLE is entered with burst_done).
- gnt_err is asserted the cycle after the offending sample.
- req_ready is combinational from state, out_valid, out_ready and beat_cnt. It has no path from req_valid.

## Configuration
- RRM_IDLE_TIMEOUT_EN defined: in XFER an idle counter counts cycles with no accepted beat and resets on each accepted beat. Reaching TIMEOUT forces XFER -> DRAIN with beat_cnt < BURST_LEN; DRAIN and burst_done then behave as normal. If no beat was accepted at all, DRAIN exits the next cycle because out_valid == 0.
- Not defined: no idle counter. A burst ends only after BURST_LEN beats, and a silent owner holds the block in XFER indefinitely.

## Test plan
- Reset then idle: gnt=0 for 10 cycles -> all outputs 0, busy 0.
- gnt=4'b0100, req_valid=4'b1111, out_ready=1, BURST_LEN=4 -> req_ready=4'b0100 for 4 cycles. out_src=2 with req_data[2] values forwarded in order. burst_done pulses once, 6 cycles after the gnt sample.
- Same as above with out_ready toggling 1,0,1,0 -> no beat lost or duplicated. req_ready low whenever out_valid && !out_ready.
- gnt changes 0001 -> 0010 during XFER -> out_src stays 0 for the whole burst. A new grant is accepted only after burst_done.
- gnt=4'b0110 in IDLE -> gnt_err pulses 1 cycle, busy stays 0.
- Reset high mid-burst after 2 beats -> out_valid 0 and state IDLE next cycle, no burst_done. With RRM_IDLE_TIMEOUT_EN: owner's req_valid low for 8 cycles after 1 beat -> DRAIN then burst_done.
